conv_acc9: RTL and testbench



---
 rtl/vgg_pkg.sv | 27 ++
 rtl/conv_acc9_if.sv | 28 ++
 rtl/adder_tree9.sv | 73 +++++++
 rtl/conv_acc9.sv | 98 +++++++++
 tb/tb_conv_acc9.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vgg_pkg.sv
// Shared definitions for the VGG reduction blocks.
//   - Default datapath widths for the PE-array reduction path.
//   - PE_LANES: number of product lanes the 3x3 PE array emits.
//   - tag_t: beat sideband (valid / first-of-window / last-of-window).
//   - sign_ext(): sign-extends the low w bits of a 64-bit container.
//     Callers size-cast the result down to their own accumulator width.
package vgg_pkg;

    localparam int DATA_WIDTH_D = 16;
    localparam int ACC_WIDTH_D  = 40;
    localparam int CH_WIDTH_D   = 10;
    localparam int PE_LANES     = 9;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // Shift the field up to bit 63, then arithmetic-shift it back down.
    function automatic logic [63:0] sign_ext(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = v << (64 - w);
        return $signed(m) >>> (64 - w);
    endfunction

endpackage

// File: rtl/conv_acc9_if.sv
// Stream bundle for conv_acc9.
//   Input side : in_valid / in_ready, multiply (nine packed signed lanes), num_ch.
//   Output side: out_valid / out_ready, out_data (signed pixel sum).
//   master: producer of beats and consumer of sums (upstream/downstream view).
//   slave : the reduction block itself.
interface conv_acc9_if #(
    parameter int DATA_WIDTH = vgg_pkg::DATA_WIDTH_D,
    parameter int ACC_WIDTH  = vgg_pkg::ACC_WIDTH_D,
    parameter int CH_WIDTH   = vgg_pkg::CH_WIDTH_D
);
    logic                                   in_valid;
    logic                                   in_ready;
    logic [DATA_WIDTH*vgg_pkg::PE_LANES-1:0] multiply;
    logic [CH_WIDTH-1:0]                    num_ch;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [ACC_WIDTH-1:0]                   out_data;

    modport master (
        output in_valid, multiply, num_ch, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, multiply, num_ch, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/adder_tree9.sv
// Two-stage registered adder tree for nine signed products.
//   S1: sign-extend all lanes, register four pair sums (8+7, 6+5, 4+3, 2+1)
//       and lane 0 unchanged.
//   S2: register the sum of the five S1 terms.
// Ports:
//   clk, rst    : clock, async active-high reset
//   i_en        : global advance; all registers hold while low
//   i_tag       : sideband of the incoming beat (valid/first/last)
//   i_multiply  : nine packed lanes, lane k at [DW*(k+1)-1 -: DW]
//   o_tag/o_sum : S2 sideband and window-sum for this beat
module adder_tree9
    import vgg_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  tag_t                           i_tag,
    input  logic [DATA_WIDTH*PE_LANES-1:0] i_multiply,
    output tag_t                           o_tag,
    output logic [ACC_WIDTH-1:0]           o_sum
);
    localparam int NPAIR = (PE_LANES - 1) / 2;

    logic [PE_LANES-1:0][ACC_WIDTH-1:0] w_ext;
    logic [NPAIR-1:0][ACC_WIDTH-1:0]    r_s1_pair;
    logic [ACC_WIDTH-1:0]               r_s1_lane0;
    tag_t                               r_s1_tag;
    logic [ACC_WIDTH-1:0]               w_s2_sum;
    logic [ACC_WIDTH-1:0]               r_s2_sum;
    tag_t                               r_s2_tag;

    for (genvar k = 0; k < PE_LANES; k++) begin : g_ext
        assign w_ext[k] = ACC_WIDTH'(sign_ext(
            64'(i_multiply[DATA_WIDTH*(k+1)-1 -: DATA_WIDTH]), DATA_WIDTH));
    end

    // Pair j covers lanes 2j+2 and 2j+1; lane 0 rides through on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_pair  <= '0;
            r_s1_lane0 <= '0;
            r_s1_tag   <= '0;
        end else if (i_en) begin
            for (int j = 0; j < NPAIR; j++)
                r_s1_pair[j] <= w_ext[2*j+2] + w_ext[2*j+1];
            r_s1_lane0 <= w_ext[0];
            r_s1_tag   <= i_tag;
        end
    end

    always_comb begin
        w_s2_sum = r_s1_lane0;
        for (int j = 0; j < NPAIR; j++)
            w_s2_sum = w_s2_sum + r_s1_pair[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_sum <= '0;
            r_s2_tag <= '0;
        end else if (i_en) begin
            r_s2_sum <= w_s2_sum;
            r_s2_tag <= r_s1_tag;
        end
    end

    assign o_sum = r_s2_sum;
    assign o_tag = r_s2_tag;

endmodule

// File: rtl/conv_acc9.sv
// Channel accumulator behind the 3x3 PE array.
// Sums nine products per beat (adder_tree9), accumulates num_ch beats per
// output pixel and emits one signed sum per pixel on a valid/ready port.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : conv_acc9_if.slave (in_valid/in_ready/multiply/num_ch,
//              out_valid/out_ready/out_data)
// A stalled output (out_valid && !out_ready) freezes every stage; in_ready
// is the only combinational output.
module conv_acc9
    import vgg_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ACC_WIDTH  = ACC_WIDTH_D,
    parameter int CH_WIDTH   = CH_WIDTH_D
) (
    input  logic        clk,
    input  logic        rst,
    conv_acc9_if.slave  bus
);
    logic                 w_en;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic [CH_WIDTH-1:0]  w_eff;
    tag_t                 w_in_tag;
    tag_t                 w_s2_tag;
    logic [ACC_WIDTH-1:0] w_s2_sum;

    logic [CH_WIDTH-1:0]  r_in_cnt;
    logic [CH_WIDTH-1:0]  r_ch_lat;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic                 r_out_valid;

    assign w_en        = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_en;
    assign w_accept    = bus.in_valid && w_en;

    // The channel count only matters on the first beat of a window; later
    // beats use the latched copy so num_ch may change freely mid-window.
    assign w_first = (r_in_cnt == '0);
    assign w_eff   = !w_first            ? r_ch_lat :
                     (bus.num_ch == '0)  ? CH_WIDTH'(1) : bus.num_ch;
    assign w_last  = (r_in_cnt == w_eff - CH_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_cnt <= '0;
            r_ch_lat <= '0;
        end else if (w_accept) begin
            if (w_first)
                r_ch_lat <= w_eff;
            r_in_cnt <= w_last ? '0 : r_in_cnt + CH_WIDTH'(1);
        end
    end

    assign w_in_tag = '{valid: w_accept, first: w_first, last: w_last};

    adder_tree9 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_tree (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_en),
        .i_tag      (w_in_tag),
        .i_multiply (bus.multiply),
        .o_tag      (w_s2_tag),
        .o_sum      (w_s2_sum)
    );

    // With w_en high the output is either empty or being taken this cycle,
    // so out_valid drops unless a new window completes right now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= 1'b0;
            if (w_s2_tag.valid) begin
                if (w_s2_tag.last) begin
                    r_out_data  <= w_s2_tag.first ? w_s2_sum : r_acc + w_s2_sum;
                    r_out_valid <= 1'b1;
                end else if (w_s2_tag.first) begin
                    r_acc <= w_s2_sum;
                end else begin
                    r_acc <= r_acc + w_s2_sum;
                end
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_conv_acc9.sv
// Randomized self-checking bench for conv_acc9 with a window-sum model.
module tb_conv_acc9;
    import vgg_pkg::*;

    localparam int DW = DATA_WIDTH_D;
    localparam int AW = ACC_WIDTH_D;
    localparam int CW = CH_WIDTH_D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_acc9_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_WIDTH(CW)) bus();

    conv_acc9 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CH_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     n_chk = 0;
    int     n_pass = 0;
    int     cyc = 0;
    longint exp_q[$];
    int     exp_cyc_q[$];
    int     m_cnt = 0;
    int     m_eff = 1;
    longint m_sum = 0;
    int     cur_lanes[PE_LANES];
    bit     acc_flag;
    bit     lat_chk = 0;
    int     rdy_mode = 0;   // 0: always ready, 1: random ready
    int     stall_left = 0; // forced out_ready=0 cycles

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic longint wrap(input longint v);
        logic [AW-1:0] t;
        t = v[AW-1:0];
        return longint'($signed(t));
    endfunction

    function automatic longint sx(input logic [AW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: a window is num_ch (0 -> 1) beats, sampled on its first beat;
    // its output is the modular sum of all lanes of all its beats.
    task automatic model_beat();
        if (m_cnt == 0) begin
            m_eff = (bus.num_ch == '0) ? 1 : int'(bus.num_ch);
            m_sum = 0;
        end
        foreach (cur_lanes[k]) m_sum += cur_lanes[k];
        m_cnt++;
        if (m_cnt == m_eff) begin
            exp_q.push_back(wrap(m_sum));
            exp_cyc_q.push_back(cyc);
            m_cnt = 0;
        end
    endtask

    // Called at posedge+1 with inputs driven; observes the cycle, then advances.
    task automatic tick();
        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
        else bus.out_ready = 1'b1;
        #1;
        acc_flag = 0;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", sx(bus.out_data), 0);
            chk("rst_in_ready", bus.in_ready, 1);
        end else begin
            chk("in_ready", bus.in_ready, (bus.out_valid && !bus.out_ready) ? 0 : 1);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("out_data", sx(bus.out_data), exp_q[0]);
                    if (bus.out_ready) begin
                        if (lat_chk) chk("latency", cyc - exp_cyc_q[0], 3);
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                model_beat();
                acc_flag = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int nch);
        bus.in_valid = 1'b1;
        bus.num_ch   = CW'(nch);
        for (int k = 0; k < PE_LANES; k++)
            bus.multiply[DW*(k+1)-1 -: DW] = DW'(cur_lanes[k]);
        for (int t = 0; t < 200; t++) begin
            tick();
            if (acc_flag) break;
        end
        if (!acc_flag) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic set_all(input int v);
        foreach (cur_lanes[k]) cur_lanes[k] = v;
    endtask

    task automatic set_rand();
        foreach (cur_lanes[k]) cur_lanes[k] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) tick();
        for (int t = 0; t < 4; t++) tick();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.num_ch    = '0;
        bus.multiply  = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();

        // Single-channel window, lane k = k+1 -> 45, three cycles later.
        lat_chk = 1;
        foreach (cur_lanes[k]) cur_lanes[k] = k + 1;
        send(1);
        drain();

        // Three channels: -18 + 9 + 900 = 891.
        set_all(-2);  send(3);
        set_all(1);   send(3);
        set_all(100); send(3);
        drain();

        // Sign-extension extremes over 4 channels.
        for (int i = 0; i < 4; i++) begin set_all(32767);  send(4); end
        for (int i = 0; i < 4; i++) begin set_all(-32768); send(4); end
        drain();
        lat_chk = 0;

        // Back-to-back single-channel beats with a 5-cycle output stall.
        for (int i = 0; i < 10; i++) begin
            if (i == 3) stall_left = 5;
            set_rand();
            send(1);
        end
        drain();

        // num_ch=0 acts as 1; mid-window num_ch change is ignored.
        for (int i = 0; i < 3; i++) begin set_rand(); send(0); end
        set_rand(); send(2);
        set_rand(); send(5);
        for (int i = 0; i < 5; i++) begin
            set_rand();
            send(i == 0 ? 5 : int'($urandom_range(0, 7)));
        end
        drain();

        // Reset mid-window discards the partial sum.
        for (int i = 0; i < 2; i++) begin set_rand(); send(4); end
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        m_cnt = 0;
        tick(); tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin set_rand(); send(4); end
        drain();

        // Random traffic: random channel counts, gaps and backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            set_rand();
            send(int'($urandom_range(0, 4)));
            if ($urandom_range(0, 4) == 0) tick();
        end
        rdy_mode = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
